// File: rtl/ctrl_pc_pkg.sv
// rtl/ctrl_pc_pkg.sv - shared encodings and constants for the pipeline control / PC unit
package ctrl_pc_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STALL    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_INC   = 32'd4;

    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/ctrl_pc_pc_reg.sv
// rtl/ctrl_pc_pc_reg.sv - program counter register with redirect, trap-vector and advance mux
module ctrl_pc_pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    input  logic        advance_en,
    output logic [31:0] pc
);
    import ctrl_pc_pkg::*;

    logic [31:0] pc_q;
    logic [31:0] pc_d;

    // A redirect always beats an advance; a misaligned target diverts to the trap vector.
    always_comb begin
        pc_d = pc_q;
        if (jump_en) begin
            pc_d = is_misaligned(jump_addr[1:0]) ? TRAP_VEC : jump_addr;
        end else if (advance_en) begin
            pc_d = pc_q + PC_INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/ctrl_pc.sv
// rtl/ctrl_pc.sv - pipeline control FSM: fetch handshake, flush/stall controls and misalignment trap
module ctrl_pc #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    input  logic        fetch_ack_i,
    output logic [31:0] pc_o,
    output logic        fetch_req_o,
    output logic        inst_valid_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        trap_o,
    output logic [31:0] bad_addr_o
);
    import ctrl_pc_pkg::*;

    state_t      state_q;
    state_t      state_d;
    logic        advance_en;
    logic        trap_q;
    logic [31:0] bad_addr_q;
    logic        trap_take;

    assign trap_take = jump_en_i && is_misaligned(jump_addr_i[1:0]);

    always_comb begin
        state_d      = state_q;
        fetch_req_o  = 1'b0;
        inst_valid_o = 1'b0;
        flush_o      = 1'b0;
        stall_o      = 1'b0;
        advance_en   = 1'b0;
        if (rst) begin
            flush_o = 1'b1;
            state_d = ST_REDIRECT;
        end else if (jump_en_i) begin
            // The request may still be acknowledged, but that fetch is thrown away.
            fetch_req_o = 1'b1;
            flush_o     = 1'b1;
            state_d     = ST_REDIRECT;
        end else if (hold_flag_i) begin
            stall_o = 1'b1;
            state_d = ST_STALL;
        end else begin
            fetch_req_o = 1'b1;
            advance_en  = fetch_ack_i;
            state_d     = ST_RUN;
            // The bubble cycle after a redirect fetches but never presents a valid instruction.
            if (state_q != ST_REDIRECT) begin
                inst_valid_o = fetch_ack_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_REDIRECT;
            trap_q     <= 1'b0;
            bad_addr_q <= 32'h0;
        end else begin
            state_q <= state_d;
            trap_q  <= trap_take;
            if (trap_take) begin
                bad_addr_q <= jump_addr_i;
            end
        end
    end

    ctrl_pc_pc_reg #(
        .RESET_PC (RESET_PC),
        .TRAP_VEC (TRAP_VEC)
    ) u_pc_reg (
        .clk        (clk),
        .rst        (rst),
        .jump_en    (jump_en_i),
        .jump_addr  (jump_addr_i),
        .advance_en (advance_en),
        .pc         (pc_o)
    );

    assign trap_o     = trap_q;
    assign bad_addr_o = bad_addr_q;

endmodule
